seg_scan_drv: RTL and testbench
===============================

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit dwell (1 ms at 50 MHz); legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  system clock, 50 MHz, rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset; one clock domain only.
REQ-004 The block SHALL have port data_in  input  20  unsigned binary count to display.
REQ-005 The block SHALL have port data_load  input  1  one-cycle strobe; data_in is sampled on the same edge.
REQ-006 The block SHALL have port blank_lz  input  1  1 = blank leading zeros.
REQ-007 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 The block SHALL have port sel  output  3  index of the active digit: 0 = least significant digit, 5 = most significant.
REQ-009 The block SHALL have port seg  output  8  active-low segments: bit0..bit6 = a..g, bit7 = dp.

Function
REQ-010 Conversion FSM SHALL have states IDLE and SHIFT; the DONE action folds into the last SHIFT cycle.
REQ-011 In IDLE, data_load=1 at edge k SHALL latch min(data_in, 999999), clear the 24-bit BCD accumulator, enter SHIFT and set busy=1 from edge k.
REQ-012 SHIFT SHALL perform one double-dabble iteration per cycle over 20 cycles at edges k+1..k+20: add 3 to each BCD nibble >=5, then shift left 1 bit with the binary MSB entering.
REQ-013 At edge k+21 the block SHALL copy the 6-nibble result into the display register, set busy=0 and return to IDLE; busy is high for exactly 21 cycles.
REQ-014 data_load asserted while busy=1 SHALL be ignored; the display register holds its old value until REQ-013.
REQ-015 data_in > 999999 SHALL display 999999.
REQ-016 The scan divider SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, the digit index SHALL advance 0,1,..,5,0 (5 wraps to 0).
REQ-017 sel and seg SHALL be registered and change on the same edge; seg always reflects the digit named by sel.
REQ-018 Decode SHALL map 0..9 to C0,F9,A4,B0,99,92,82,F8,80,90 (hex); any other nibble SHALL map to FF; dp (bit7) SHALL always be 1.
REQ-019 With blank_lz=1, digit i (i>=1) SHALL output FF when it and every more-significant digit are 0; digit 0 SHALL never be blanked.
REQ-020 Scanning SHALL continue undisturbed during conversion; the display register changes only at REQ-013.
REQ-021 A display-register update SHALL take effect on the next digit shown, without resetting the scan position.

Reset
REQ-022 On rst_n=0, regardless of clk, the block SHALL set: FSM=IDLE, busy=0, BCD accumulator=0, display register=0, divider=0, sel=0, seg=C0.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion, and the display SHALL show 0 after release.
REQ-024 After rst_n deasserts, the first digit advance SHALL occur SCAN_DIV cycles after the first clk edge.

Verification (SCAN_DIV=4)
REQ-025 Scenario: reset release, no load -> sel=0, seg=C0, busy=0; sel steps 0..5 every 4 cycles; with blank_lz=0, digits 1..5 show C0.
REQ-026 Scenario: load 123456 -> busy high for 21 cycles; then sel0=82, sel1=92, sel2=99, sel3=B0, sel4=A4, sel5=F9.
REQ-027 Scenario: load 1000000 -> all six digits show 90.
REQ-028 Scenario: load 42 with blank_lz=1 -> sel0=A4, sel1=99, sel2..5=FF; toggle blank_lz=0 -> sel2..5=C0.
REQ-029 Scenario: load 7, then load 5 three cycles later while busy -> the second load is ignored; display shows 7 (sel0=F8).
REQ-030 Scenario: display holds 123456, load 999 and pulse rst_n low at cycle 10 of busy -> busy=0 immediately; all digits C0 (blank_lz=0).

Source files
------------

// File: rtl/seg_scan_drv.sv
//------------------------------------------------------------------------------
// seg_scan_drv : binary-to-BCD converter driving a 6-digit multiplexed display
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_drv #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] data_in,
  input  logic        data_load,
  input  logic        blank_lz,
  output logic        busy,
  output logic [2:0]  sel,
  output logic [7:0]  seg
);

  localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [19:0] MAX_VALUE = 20'd999999;
  localparam logic [4:0]  LAST_CNT  = 5'd20;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d;
  logic [23:0] disp_q, disp_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;
  logic [23:0] adj;
  logic        wrap;

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 8'hC0;
      4'd1:    decode = 8'hF9;
      4'd2:    decode = 8'hA4;
      4'd3:    decode = 8'hB0;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h92;
      4'd6:    decode = 8'h82;
      4'd7:    decode = 8'hF8;
      4'd8:    decode = 8'h80;
      4'd9:    decode = 8'h90;
      default: decode = 8'hFF;
    endcase
  endfunction

  // A digit is blank when it and everything above it are zero (never digit 0).
  function automatic logic [7:0] digit_seg(input logic [2:0] idx,
                                           input logic [23:0] d,
                                           input logic blz);
    logic [23:0] upper;
    upper = d >> {idx, 2'b00};
    if (blz && (idx != 3'd0) && (upper == 24'd0))
      digit_seg = 8'hFF;
    else
      digit_seg = decode(upper[3:0]);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    adj     = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (data_load) begin
          bin_d   = (data_in > MAX_VALUE) ? MAX_VALUE : data_in;
          bcd_d   = 24'd0;
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          disp_d  = bcd_q;
          state_d = IDLE;
        end else begin
          bcd_d = {adj[22:0], bin_q[19]};
          bin_d = {bin_q[18:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Segments are refreshed only on a digit advance, so a new display value
  // appears from the next digit shown without disturbing the scan position.
  always_comb begin
    wrap  = (div_q == DIV_LAST);
    div_d = wrap ? 16'd0 : div_q + 16'd1;
    sel_d = sel_q;
    seg_d = seg_q;
    if (wrap) begin
      sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
      seg_d = digit_seg(sel_d, disp_q, blank_lz);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      bin_q   <= 20'd0;
      bcd_q   <= 24'd0;
      disp_q  <= 24'd0;
      div_q   <= 16'd0;
      sel_q   <= 3'd0;
      seg_q   <= 8'hC0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign sel  = sel_q;
  assign seg  = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_drv.sv
//------------------------------------------------------------------------------
// tb_seg_scan_drv : directed self-checking bench for seg_scan_drv (SCAN_DIV=4)
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_drv;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [19:0] data_in = 20'd0;
  logic        data_load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        busy;
  logic [2:0]  sel;
  logic [7:0]  seg;

  int n_cmp  = 0;
  int n_fail = 0;

  seg_scan_drv #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_load (data_load),
    .blank_lz  (blank_lz),
    .busy      (busy),
    .sel       (sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for sel to newly enter digit d, then check its segments.
  task automatic see_digit(input logic [2:0] d, input logic [7:0] exp, input string tag);
    int n = 0;
    while (sel == d && n < 60) begin @(negedge clk); n++; end
    while (sel != d && n < 60) begin @(negedge clk); n++; end
    chk({tag, "_sel"}, {29'd0, sel}, {29'd0, d});
    chk(tag, {24'd0, seg}, {24'd0, exp});
  endtask

  task automatic do_load(input logic [19:0] v);
    @(negedge clk);
    data_in   = v;
    data_load = 1'b1;
    @(posedge clk);
    #1;
    data_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sel",  {29'd0, sel},  32'd0);
    chk("rst_seg",  {24'd0, seg},  32'hC0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan timing: first advance on the SCAN_DIV-th edge after release
    repeat (3) @(posedge clk);
    #1 chk("no_early_adv", {29'd0, sel}, 32'd0);
    @(posedge clk);
    #1;
    chk("adv_sel1", {29'd0, sel}, 32'd1);
    chk("adv_seg1", {24'd0, seg}, 32'hC0);
    for (int i = 2; i <= 5; i++) begin
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("adv_sel%0d", i), {29'd0, sel}, i);
      chk($sformatf("adv_seg%0d", i), {24'd0, seg}, 32'hC0);
    end
    repeat (4) @(posedge clk);
    #1 chk("adv_wrap", {29'd0, sel}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 123456, busy exactly 21 cycles
    do_load(20'd123456);
    chk("busy_k", {31'd0, busy}, 32'd1);
    repeat (20) @(posedge clk);
    #1 chk("busy_k20", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 chk("busy_k21", {31'd0, busy}, 32'd0);
    see_digit(3'd0, 8'h82, "n123456_d0");
    see_digit(3'd1, 8'h92, "n123456_d1");
    see_digit(3'd2, 8'h99, "n123456_d2");
    see_digit(3'd3, 8'hB0, "n123456_d3");
    see_digit(3'd4, 8'hA4, "n123456_d4");
    see_digit(3'd5, 8'hF9, "n123456_d5");

    // Saturation
    do_load(20'd1000000);
    wait_idle("sat_idle");
    for (int i = 0; i < 6; i++)
      see_digit(3'(i), 8'h90, $sformatf("sat_d%0d", i));

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(20'd42);
    wait_idle("n42_idle");
    see_digit(3'd0, 8'hA4, "n42_d0");
    see_digit(3'd1, 8'h99, "n42_d1");
    for (int i = 2; i < 6; i++)
      see_digit(3'(i), 8'hFF, $sformatf("n42_blank_d%0d", i));
    blank_lz = 1'b0;
    for (int i = 2; i < 6; i++)
      see_digit(3'(i), 8'hC0, $sformatf("n42_zero_d%0d", i));

    // Load while busy is ignored
    do_load(20'd7);
    repeat (2) @(posedge clk);
    do_load(20'd5);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    wait_idle("ign_idle");
    repeat (3) @(posedge clk);
    #1 chk("ign_no_reconv", {31'd0, busy}, 32'd0);
    see_digit(3'd0, 8'hF8, "ign_d0");
    see_digit(3'd1, 8'hC0, "ign_d1");

    // Reset mid-conversion
    do_load(20'd123456);
    wait_idle("pre_rst_idle");
    see_digit(3'd0, 8'h82, "pre_rst_d0");
    do_load(20'd999);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sel",  {29'd0, sel},  32'd0);
    chk("mid_rst_seg",  {24'd0, seg},  32'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("post_rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 1; i < 6; i++)
      see_digit(3'(i), 8'hC0, $sformatf("post_rst_d%0d", i));
    see_digit(3'd0, 8'hC0, "post_rst_d0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
